// File: rtl/fir_pkg.sv
// Shared parameters, coefficient set and helpers for the fixed-coefficient FIR core.
package fir_pkg;

  localparam int unsigned WIDTH     = 24;
  localparam int unsigned TAPS      = 8;
  localparam int unsigned COEF_W    = 18;
  localparam int unsigned COEF_FRAC = 17;

  typedef logic signed [WIDTH-1:0] sample_t;

  // Q1.17 low-pass set, symmetric; element [k] multiplies x[k]
  localparam logic [TAPS-1:0][COEF_W-1:0] COEFS = {
    -18'sd1311, 18'sd0, 18'sd13107, 18'sd53740,
    18'sd53740, 18'sd13107, 18'sd0, -18'sd1311
  };

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fir_filter_core_if.sv
// Sample-in / filtered-sample-out bus between the sample source, the FIR core and its consumers.
interface fir_filter_core_if
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = fir_pkg::WIDTH
);
  logic signed [WIDTH-1:0] input_sig;
  logic                    ready;
  logic signed [WIDTH-1:0] filtred_sig;
  logic                    out_valid;

  modport master (output input_sig, ready, input filtred_sig, out_valid);
  modport slave  (input input_sig, ready, output filtred_sig, out_valid);
endinterface

// File: rtl/fir_filter.sv
// Direct-form FIR: one multiplier per tap.
module fir_filter
  import fir_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fir_filter_core_if.slave bus
);

  fir_filter_core #(.STRUCTURE(0)) u_core (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

endmodule

// File: rtl/fir_filter_sep.sv
// Symmetric (folded) FIR: pre-adds mirrored taps to halve the multiplier count.
module fir_filter_sep
  import fir_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fir_filter_core_if.slave bus
);

  fir_filter_core #(.STRUCTURE(1)) u_core (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

endmodule

// File: rtl/fir_mac_tree.sv
// Registered multipliers followed by a combinational adder tree; operands arrive pre-added
// when the folded structure is used, so both structures share this block unchanged.
module fir_mac_tree
  import fir_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned OP_W   = 25,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned ACC_W  = 46
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  input  logic signed [OP_W-1:0]   i_op   [N],
  input  logic signed [COEF_W-1:0] i_coef [N],
  output logic                     o_vld,
  output logic signed [ACC_W-1:0]  o_acc_c
);

  localparam int unsigned PROD_W = OP_W + COEF_W;

  logic signed [PROD_W-1:0] r_prod [N];
  logic                     r_vld;

  // Product stage only loads on a valid sample so it holds across idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) r_prod[k] <= '0;
      r_vld <= 1'b0;
    end else begin
      if (i_vld) begin
        for (int k = 0; k < int'(N); k++)
          r_prod[k] <= PROD_W'(i_op[k]) * PROD_W'(i_coef[k]);
      end
      r_vld <= i_vld;
    end
  end

  always_comb begin
    o_acc_c = '0;
    for (int k = 0; k < int'(N); k++) o_acc_c = o_acc_c + ACC_W'(r_prod[k]);
  end

  assign o_vld = r_vld;

endmodule

// File: rtl/fir_filter_core.sv
// Sample-strobed signed FIR: delay line -> registered products -> registered round/saturate.
// STRUCTURE selects direct form or symmetric pre-add; both give bit-identical outputs.
module fir_filter_core
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH     = fir_pkg::WIDTH,
  parameter int unsigned TAPS      = fir_pkg::TAPS,
  parameter int unsigned COEF_W    = fir_pkg::COEF_W,
  parameter int unsigned COEF_FRAC = fir_pkg::COEF_FRAC,
  parameter int unsigned STRUCTURE = 0,
  parameter logic [TAPS-1:0][COEF_W-1:0] COEFS = fir_pkg::COEFS
) (
  input  logic clk,
  input  logic rst,
  fir_filter_core_if.slave bus
);

  localparam int unsigned OP_W  = WIDTH + 1;
  localparam int unsigned N_MUL = (STRUCTURE != 0) ? (TAPS + 1) / 2 : TAPS;
  localparam int unsigned ACC_W = WIDTH + COEF_W + clog2(TAPS) + 1;
  localparam int unsigned RND_W = ACC_W + 1;

  localparam logic signed [RND_W-1:0] HALF    = RND_W'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [RND_W-1:0] SAT_MAX = (RND_W'(1) <<< (WIDTH - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [WIDTH-1:0]  r_x [TAPS];
  logic                     r_x_vld;
  logic signed [OP_W-1:0]   w_op   [N_MUL];
  logic signed [COEF_W-1:0] w_coef [N_MUL];
  logic                     w_mac_vld;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [RND_W-1:0]  w_rnd;
  logic signed [RND_W-1:0]  w_shr;
  logic signed [WIDTH-1:0]  w_sat;
  logic signed [WIDTH-1:0]  r_out;
  logic                     r_out_vld;

  // Delay line advances only on a strobe; validity travels every clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(TAPS); k++) r_x[k] <= '0;
      r_x_vld <= 1'b0;
    end else begin
      if (bus.ready) begin
        r_x[0] <= bus.input_sig;
        for (int k = 1; k < int'(TAPS); k++) r_x[k] <= r_x[k-1];
      end
      r_x_vld <= bus.ready;
    end
  end

  // Folded form pairs x[k] with its mirror; the unpaired middle tap passes through
  always_comb begin
    for (int k = 0; k < int'(N_MUL); k++) begin
      w_coef[k] = COEFS[k];
      if (STRUCTURE == 0 || ((TAPS % 2) == 1 && k == int'(TAPS / 2)))
        w_op[k] = OP_W'(r_x[k]);
      else
        w_op[k] = OP_W'(r_x[k]) + OP_W'(r_x[int'(TAPS) - 1 - k]);
    end
  end

  fir_mac_tree #(
    .N      (N_MUL),
    .OP_W   (OP_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (r_x_vld),
    .i_op    (w_op),
    .i_coef  (w_coef),
    .o_vld   (w_mac_vld),
    .o_acc_c (w_acc)
  );

  // Round half up, then clamp to the output range
  always_comb begin
    w_rnd = RND_W'(w_acc) + HALF;
    w_shr = w_rnd >>> COEF_FRAC;
    if (w_shr > SAT_MAX)      w_sat = SAT_MAX[WIDTH-1:0];
    else if (w_shr < SAT_MIN) w_sat = SAT_MIN[WIDTH-1:0];
    else                      w_sat = w_shr[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_mac_vld) r_out <= w_sat;
      r_out_vld <= w_mac_vld;
    end
  end

  assign bus.filtred_sig = r_out;
  assign bus.out_valid   = r_out_vld;

endmodule

// File: tb/tb_fir_filter_core.sv
// Directed bench for fir_filter_core: direct and folded instances driven in lockstep.
module tb_fir_filter_core;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic signed [WIDTH-1:0] r_in;
  logic r_rdy;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fir_filter_core_if #(.WIDTH(WIDTH)) if_d ();
  fir_filter_core_if #(.WIDTH(WIDTH)) if_s ();

  assign if_d.input_sig = r_in;
  assign if_d.ready     = r_rdy;
  assign if_s.input_sig = r_in;
  assign if_s.ready     = r_rdy;

  fir_filter_core #(.STRUCTURE(0)) u_dir (.clk(clk), .rst(rst), .bus(if_d));
  fir_filter_core #(.STRUCTURE(1)) u_sep (.clk(clk), .rst(rst), .bus(if_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; r_rdy = 1'b0; r_in = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (if_d.out_valid !== 1'b0 || if_d.filtred_sig !== 24'sd0 || if_s.out_valid !== 1'b0 || if_s.filtred_sig !== 24'sd0)
      $display("FAIL reset_state: dir=%0d/%b sep=%0d/%b exp=0/0", if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid);
    else n_pass++;
    r_in = 24'sd131072; r_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_chk++;
    if (if_d.out_valid !== 1'b1 || if_d.filtred_sig !== -24'sd1311 || if_s.out_valid !== 1'b1 || if_s.filtred_sig !== -24'sd1311)
      $display("FAIL pre_reset_out: dir=%0d/%b sep=%0d/%b exp=-1311/1", if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if (if_d.out_valid !== 1'b0 || if_d.filtred_sig !== 24'sd0 || if_s.out_valid !== 1'b0 || if_s.filtred_sig !== 24'sd0)
      $display("FAIL reset_async: dir=%0d/%b sep=%0d/%b exp=0/0", if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid);
    else n_pass++;
    tick();
    rst = 1'b0; r_rdy = 1'b0; r_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (if_d.out_valid !== 1'b0 || if_d.filtred_sig !== 24'sd0 || if_s.out_valid !== 1'b0 || if_s.filtred_sig !== 24'sd0)
        $display("FAIL reset_flush[%0d]: dir=%0d/%b sep=%0d/%b exp=0/0", i, if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid);
      else n_pass++;
    end
    r_in = 24'sd131072; r_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      r_rdy = 1'b0; r_in = '0;
      n_chk++;
      if (i < 3) begin
        if (if_d.out_valid !== 1'b0 || if_s.out_valid !== 1'b0)
          $display("FAIL reset_first_lat[%0d]: dir_vld=%b sep_vld=%b exp=0", i, if_d.out_valid, if_s.out_valid);
        else n_pass++;
      end else begin
        if (if_d.out_valid !== 1'b1 || if_d.filtred_sig !== -24'sd1311 || if_s.out_valid !== 1'b1 || if_s.filtred_sig !== -24'sd1311)
          $display("FAIL reset_first_out: dir=%0d/%b sep=%0d/%b exp=-1311/1", if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid);
        else n_pass++;
      end
    end
  endtask

  // Single strobe of amp followed by zeros; exp holds the hand-computed output train
  task automatic run_impulse(input string name, input int amp, input int exp [9]);
    do_reset();
    r_in = WIDTH'(amp); r_rdy = 1'b1;
    tick();
    r_in = '0;
    n_chk++;
    if (if_d.out_valid !== 1'b0 || if_s.out_valid !== 1'b0)
      $display("FAIL %s_early: dir_vld=%b sep_vld=%b exp=0", name, if_d.out_valid, if_s.out_valid);
    else n_pass++;
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      n_chk++;
      if (if_d.out_valid !== 1'b1 || if_d.filtred_sig !== exp[k] || if_s.out_valid !== 1'b1 || if_s.filtred_sig !== exp[k])
        $display("FAIL %s[%0d]: dir=%0d/%b sep=%0d/%b exp=%0d/1", name, k, if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid, exp[k]);
      else n_pass++;
    end
    r_rdy = 1'b0;
  endtask

  task automatic test_impulse();
    int exp [9] = '{-1311, 0, 13107, 53740, 53740, 13107, 0, -1311, 0};
    run_impulse("impulse", 131072, exp);
  endtask

  task automatic test_rounding();
    int exp1 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp3 [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    run_impulse("round_in1", 1, exp1);
    run_impulse("round_in3", 3, exp3);
  endtask

  task automatic test_dc_saturation();
    int lvl [2] = '{8388607, -8388608};
    do_reset();
    r_rdy = 1'b1;
    for (int j = 0; j < 2; j++) begin
      r_in = WIDTH'(lvl[j]);
      for (int i = 0; i < 12; i++) tick();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (if_d.out_valid !== 1'b1 || if_d.filtred_sig !== lvl[j] || if_s.out_valid !== 1'b1 || if_s.filtred_sig !== lvl[j])
          $display("FAIL dc_%0d[%0d]: dir=%0d sep=%0d exp=%0d", j, i, if_d.filtred_sig, if_s.filtred_sig, lvl[j]);
        else n_pass++;
        tick();
      end
    end
    r_rdy = 1'b0;
  endtask

  task automatic test_strobe_gating();
    int exp [9] = '{-1311, 0, 13107, 53740, 53740, 13107, 0, -1311, 0};
    int prev;
    do_reset();
    prev = 0;
    for (int s = 0; s < 9; s++) begin
      r_in = (s == 0) ? 24'sd131072 : 24'sd0;
      r_rdy = 1'b1;
      tick();
      r_rdy = 1'b0; r_in = 24'sd99;
      for (int e = 1; e <= 3; e++) begin
        if (e > 1) tick();
        n_chk++;
        if (e < 3) begin
          if (if_d.out_valid !== 1'b0 || if_d.filtred_sig !== prev || if_s.out_valid !== 1'b0 || if_s.filtred_sig !== prev)
            $display("FAIL gate_hold[%0d.%0d]: dir=%0d/%b sep=%0d/%b exp=%0d/0", s, e, if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid, prev);
          else n_pass++;
        end else begin
          if (if_d.out_valid !== 1'b1 || if_d.filtred_sig !== exp[s] || if_s.out_valid !== 1'b1 || if_s.filtred_sig !== exp[s])
            $display("FAIL gate_out[%0d]: dir=%0d/%b sep=%0d/%b exp=%0d/1", s, if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid, exp[s]);
          else n_pass++;
        end
      end
      prev = exp[s];
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    r_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 5)       r_in = -24'sd8388608;
      else if (i % 16 == 11) r_in = 24'sd8388607;
      else                   r_in = WIDTH'($urandom);
      tick();
      n_chk++;
      if ((if_d.filtred_sig ^ if_s.filtred_sig) !== 24'd0 || (i >= 2 && (if_d.out_valid !== 1'b1 || if_s.out_valid !== 1'b1)))
        $display("FAIL equiv[%0d]: dir=%0d/%b sep=%0d/%b", i, if_d.filtred_sig, if_d.out_valid, if_s.filtred_sig, if_s.out_valid);
      else n_pass++;
    end
    r_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; r_rdy = 1'b0; r_in = '0;
    test_reset();
    test_impulse();
    test_dc_saturation();
    test_strobe_gating();
    test_rounding();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
